// File: rtl/trace_pkg.sv
// Shared types and default sizing for the instruction trace buffer.
package trace_pkg;

   localparam int DEF_DEPTH       = 16;
   localparam int DEF_SEQ_W       = 16;
   localparam int DEF_DROP_W      = 8;
   localparam int DEF_HALT_CYCLES = 8;

   typedef struct packed {
      logic [31:0]          pc;
      logic [31:0]          inst;
      logic [DEF_SEQ_W-1:0] seq;
   } trace_entry_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module trace_fifo_mem
   import trace_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int WIDTH = $bits(trace_entry_t)
) (
   input  logic             clk_in,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_in) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/inst_trace_buffer.sv
// Retired pc/inst capture FIFO with sequence tags, drop counting and show-ahead drain.
// Optional halt detection (repeated identical pc) is built when TRACE_HALT_DETECT_EN is defined.
module inst_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH       = DEF_DEPTH,
   parameter int PTR_W       = $clog2(DEPTH),
   parameter int SEQ_W       = DEF_SEQ_W,
   parameter int DROP_W      = DEF_DROP_W
`ifdef TRACE_HALT_DETECT_EN
   ,
   parameter int HALT_CYCLES = DEF_HALT_CYCLES
`endif
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              trace_en,
   input  logic              clear,
   input  logic [31:0]       pc,
   input  logic [31:0]       inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_inst,
   output logic [SEQ_W-1:0]  out_seq,
   output logic [PTR_W:0]    count,
   output logic              full,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              halted
);

   localparam int ENTRY_W = 64 + SEQ_W;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic              overflow_q, overflow_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic              capture, pop, push, drop_now, full_int;
   logic [ENTRY_W-1:0] rd_data;

`ifdef TRACE_HALT_DETECT_EN
   localparam int SAME_W = $clog2(HALT_CYCLES + 1);
   // Comparing the pre-increment value means the halting sample is the HALT_CYCLES-th identical one.
   localparam logic [SAME_W-1:0] HALT_TRIG = SAME_W'(HALT_CYCLES - 2);
   localparam logic [SAME_W-1:0] SAME_MAX  = SAME_W'(HALT_CYCLES);

   logic              halted_q, halted_d;
   logic [SAME_W-1:0] same_cnt_q, same_cnt_d;
   logic [31:0]       last_pc_q, last_pc_d;

   assign capture = trace_en && !halted_q;
   assign halted  = halted_q;

   always_comb begin
      halted_d   = halted_q;
      same_cnt_d = same_cnt_q;
      last_pc_d  = last_pc_q;
      if (clear) begin
         halted_d   = 1'b0;
         same_cnt_d = '0;
      end else if (capture) begin
         last_pc_d = pc;
         if (pc == last_pc_q) begin
            if (same_cnt_q != SAME_MAX) same_cnt_d = same_cnt_q + 1'b1;
            if (same_cnt_q == HALT_TRIG) halted_d = 1'b1;
         end else begin
            same_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         halted_q   <= 1'b0;
         same_cnt_q <= '0;
         last_pc_q  <= '0;
      end else begin
         halted_q   <= halted_d;
         same_cnt_q <= same_cnt_d;
         last_pc_q  <= last_pc_d;
      end
   end
`else
   assign capture = trace_en;
   assign halted  = 1'b0;
`endif

   always_comb begin
      full_int   = (count_q == (PTR_W+1)'(DEPTH));
      pop        = (count_q != '0) && out_ready;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      push       = capture && (!full_int || pop);
      drop_now   = capture && full_int && !pop;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      seq_d      = seq_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
         if (capture) seq_d = seq_q + 1'b1;
         if (drop_now) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         seq_q      <= seq_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   trace_fifo_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .WIDTH (ENTRY_W)
   ) u_mem (
      .clk_in  (clk_in),
      .wr_en   (push && !clear && !reset),
      .wr_addr (wr_ptr_q),
      .wr_data ({pc, inst, seq_q}),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   assign out_valid = (count_q != '0);
   assign {out_pc, out_inst, out_seq} = out_valid ? rd_data : '0;
   assign count     = count_q;
   assign full      = full_int;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

endmodule
